display_buffer_writer: RTL

Writer side of the calculator's character display buffer. Accepts 4-bit symbol codes (digits 0–9, `+ - * / =` as 4'hA–4'hE) through a valid/ready handshake, plus clear and backspace commands. It packs them into the flat `numbers` vector that the VGA text renderer reads, cell 0 in bits [3:0]. Sits between the stack-calculator core and the VGA picture generator.

---
 rtl/display_buffer_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/display_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module  : display_buffer_writer
// Brief   : Packs handshaked 4-bit calculator symbols into the VGA text buffer,
//           with backspace and a cell-per-cycle clear. Optional macro
//           DISPLAY_FRAME_SYNC_EN shadows the buffer once per frame.
// Revision: 1.0 - initial release
// ============================================================================
module display_buffer_writer #(
    parameter int NUM_CHARS = 96,
    parameter int CNT_W     = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sym_valid,
    input  logic [3:0]             sym_code,
    output logic                   sym_ready,
    input  logic                   bksp,
    input  logic                   clr,
    input  logic                   vga_v_sync,
    output logic [4*NUM_CHARS-1:0] numbers,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [3:0]       c_blank    = 4'hF;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(NUM_CHARS);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_CHARS - 1);

    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_clr_idx;
    logic [4*NUM_CHARS-1:0] r_wbuf;

    logic                   w_full;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_cnt_m1;
    logic [CNT_W+1:0]       w_wr_pos;
    logic [CNT_W+1:0]       w_bk_pos;
    logic [CNT_W+1:0]       w_clr_pos;

    assign w_full    = (r_count == c_full_cnt);
    assign sym_ready = (r_state == IDLE) & ~w_full & ~clr & ~bksp;
    assign w_accept  = sym_valid & sym_ready;
    assign w_cnt_m1  = r_count - 1'b1;
    // Bit offsets of the target cell (cell index times four).
    assign w_wr_pos  = {r_count, 2'b00};
    assign w_bk_pos  = {w_cnt_m1, 2'b00};
    assign w_clr_pos = {r_clr_idx, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_clr_idx <= '0;
            r_wbuf    <= '1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state   <= CLEAR;
                        r_clr_idx <= '0;
                    end else if (bksp && (r_count != '0)) begin
                        r_wbuf[w_bk_pos +: 4] <= c_blank;
                        r_count               <= w_cnt_m1;
                    end else if (w_accept) begin
                        r_wbuf[w_wr_pos +: 4] <= sym_code;
                        r_count               <= r_count + 1'b1;
                    end
                end
                CLEAR: begin
                    r_wbuf[w_clr_pos +: 4] <= c_blank;
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign count = r_count;
    assign full  = w_full;
    assign busy  = (r_state == CLEAR);

`ifdef DISPLAY_FRAME_SYNC_EN
    logic                   r_vs_q;
    logic                   r_vs_prev;
    logic                   r_commit;
    logic [4*NUM_CHARS-1:0] r_shadow;

    // Falling edge of the synchronised v_sync arms a commit for the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_q    <= 1'b1;
            r_vs_prev <= 1'b1;
            r_commit  <= 1'b0;
            r_shadow  <= '1;
        end else begin
            r_vs_q    <= vga_v_sync;
            r_vs_prev <= r_vs_q;
            r_commit  <= r_vs_prev & ~r_vs_q;
            if (r_commit && (r_state == IDLE)) begin
                r_shadow <= r_wbuf;
            end
        end
    end

    assign numbers = r_shadow;
`else
    logic w_unused_vsync;
    assign w_unused_vsync = vga_v_sync;
    assign numbers        = r_wbuf;
`endif

endmodule
`default_nettype wire
